// File: rtl/dac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dac_seq_pkg
//  Brief    : Shared constants and state encoding for the DAC sample sequencer
//  Revision : 1.0  initial release
// ============================================================================
package dac_seq_pkg;

    // Code width of the segmented-capacitor DAC macro
    localparam int DAC_BITS  = 10;

    // Number of cycles the macro RST pin is held high
    localparam int RESET_CYC = 2;

    // Sequencer state encoding
    typedef logic [1:0] dac_state_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RESET  = 2'd1;
    localparam logic [1:0] WARMUP = 2'd2;
    localparam logic [1:0] RUN    = 2'd3;

    // Larger of two integers, used to size shared counters
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : dac_seq_pkg
`default_nettype wire

// File: rtl/dac_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dac_seq_fifo
//  Brief    : Synchronous FIFO with push, pop, flush, occupancy and flags.
//             Flush overrides a same-cycle push and pop. The level counter is
//             one bit wider than the pointers so full and empty are distinct.
//  Revision : 1.0  initial release
// ============================================================================
module dac_seq_fifo
    import dac_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = DAC_BITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // Qualified operations: a flush cancels both, full/empty guard the rest
    assign w_push = i_push && !i_flush && !o_full;
    assign w_pop  = i_pop  && !i_flush && !o_empty;

    // Storage write; contents need no reset because the level gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_level = r_level;
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule : dac_seq_fifo
`default_nettype wire

// File: rtl/dac_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dac_sample_sequencer
//  Brief    : Drives EN/RST/SELD of the 10-bit segmented-capacitor DAC macro.
//             Runs a reset and warm-up sequence, then releases buffered codes
//             at a programmable sample rate. All macro pins are registered.
//  Revision : 1.0  initial release
// ============================================================================
module dac_sample_sequencer
    import dac_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PRESC_W    = 16,
    parameter int WARMUP_CYC = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [PRESC_W-1:0]            clk_div,
    input  logic [DAC_BITS-1:0]           wdata,
    input  logic                          wvalid,
    output logic                          wready,
    input  logic                          flush,
    input  logic                          underflow_clr,
    output logic                          dac_en,
    output logic                          dac_rst,
    output logic [DAC_BITS-1:0]           dac_sel,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          busy
);

    localparam int CNT_W = $clog2(max2(WARMUP_CYC, RESET_CYC) + 1);
    localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] C_WARM_LAST = CNT_W'(WARMUP_CYC - 1);

    dac_state_t           r_state;
    dac_state_t           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   r_period;
    logic                 w_tick;
    logic                 w_push;
    logic                 w_pop;
    logic [DAC_BITS-1:0]  w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 r_dac_en;
    logic                 r_dac_rst;
    logic [DAC_BITS-1:0]  r_dac_sel;
    logic                 r_underflow;
    logic                 r_busy;

    // Sample buffer between the bus writer and the macro
    dac_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DAC_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_wdata (wdata),
        .o_rdata (w_fifo_rdata),
        .o_level (fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A sample tick only fires while RUN is sustained; a cycle with enable low
    // is already leaving for IDLE and must not consume a code.
    assign w_tick = (r_state == RUN) && enable && (r_presc == r_period);
    assign w_push = wvalid && !w_fifo_full;
    assign w_pop  = w_tick && !w_fifo_empty && !flush;
    assign wready = !w_fifo_full;

    // Next-state decode; enable low always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = RESET;
                RESET:   if (r_cnt == C_RST_LAST)  w_state_nxt = WARMUP;
                WARMUP:  if (r_cnt == C_WARM_LAST) w_state_nxt = RUN;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register and per-state cycle counter, cleared on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (w_state_nxt == IDLE)) begin
                r_cnt <= '0;
            end else if (r_state != RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Prescaler; the period is latched only on reload so a live clk_div
    // change never truncates the running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_period <= '0;
        end else if ((r_state != RUN) || w_tick) begin
            r_presc  <= '0;
            r_period <= clk_div;
        end else begin
            r_presc  <= r_presc + PRESC_W'(1);
        end
    end

    // Macro pin registers, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dac_en  <= 1'b0;
            r_dac_rst <= 1'b0;
            r_dac_sel <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_dac_rst <= (w_state_nxt == RESET);
            r_dac_en  <= (w_state_nxt == WARMUP) || (w_state_nxt == RUN);
            r_busy    <= (w_state_nxt != IDLE);
            if (w_state_nxt == IDLE) begin
                r_dac_sel <= '0;
            end else if (w_pop) begin
                r_dac_sel <= w_fifo_rdata;
            end
        end
    end

    // Sticky underflow; a flush makes a same-cycle tick see an empty FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (w_tick && (w_fifo_empty || flush)) begin
            r_underflow <= 1'b1;
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign dac_en    = r_dac_en;
    assign dac_rst   = r_dac_rst;
    assign dac_sel   = r_dac_sel;
    assign underflow = r_underflow;
    assign busy      = r_busy;

endmodule : dac_sample_sequencer
`default_nettype wire

// File: tb/tb_dac_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_sample_sequencer
//  Brief    : Self-checking bench for dac_sample_sequencer against a
//             timeline/queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dac_sample_sequencer;

    localparam int DEPTH = 16;
    localparam int PW    = 16;
    localparam int W     = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [PW-1:0] clk_div;
    logic [9:0]    wdata;
    logic          wvalid;
    logic          wready;
    logic          flush;
    logic          underflow_clr;
    logic          dac_en;
    logic          dac_rst;
    logic [9:0]    dac_sel;
    logic [LW-1:0] fifo_level;
    logic          underflow;
    logic          busy;

    always #5 clk = ~clk;

    dac_sample_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .PRESC_W    (PW),
        .WARMUP_CYC (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .clk_div       (clk_div),
        .wdata         (wdata),
        .wvalid        (wvalid),
        .wready        (wready),
        .flush         (flush),
        .underflow_clr (underflow_clr),
        .dac_en        (dac_en),
        .dac_rst       (dac_rst),
        .dac_sel       (dac_sel),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference model: m_k is the index of the current cycle within the
    // enable sequence (0 = idle, enable rising seen in cycle 0).
    logic [9:0] q[$];
    int         m_k;
    int         m_cyc;
    int         m_next_tick;
    logic       e_en, e_rst, e_busy, e_uf;
    logic [9:0] e_sel;

    task automatic model_reset();
        q.delete();
        m_k         = 0;
        m_next_tick = -1;
        e_en = 0; e_rst = 0; e_busy = 0; e_uf = 0; e_sel = '0;
    endtask

    task automatic model_step();
        int         nk;
        int         size0;
        bit         tick;
        bit         popped;
        logic [9:0] pv;
        size0  = q.size();
        tick   = (m_k >= 3 + W) && enable && (m_cyc == m_next_tick);
        popped = 0;
        pv     = '0;
        if (tick && (flush || size0 == 0)) e_uf = 1;
        else if (underflow_clr)            e_uf = 0;
        if (flush) begin
            q.delete();
        end else begin
            if (tick && size0 > 0) begin
                pv     = q.pop_front();
                popped = 1;
            end
            if (wvalid && size0 < DEPTH) q.push_back(wdata);
        end
        nk = enable ? m_k + 1 : 0;
        if (enable && m_k == 2 + W) m_next_tick = m_cyc + 1 + int'(clk_div);
        if (tick)                   m_next_tick = m_cyc + 1 + int'(clk_div);
        e_rst  = (nk == 1) || (nk == 2);
        e_en   = (nk >= 3);
        e_busy = (nk >= 1);
        if (nk == 0)     e_sel = '0;
        else if (popped) e_sel = pv;
        m_k = nk;
        m_cyc++;
    endtask

    task automatic check_all();
        check("dac_en",     32'(dac_en),     32'(e_en));
        check("dac_rst",    32'(dac_rst),    32'(e_rst));
        check("dac_sel",    32'(dac_sel),    32'(e_sel));
        check("busy",       32'(busy),       32'(e_busy));
        check("underflow",  32'(underflow),  32'(e_uf));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("wready",     32'(wready),     32'(q.size() < DEPTH));
    endtask

    // One clock: model advances with the DUT, outputs compared at negedge
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        flush         = 1'b0;
        underflow_clr = 1'b0;
    endtask

    task automatic push_word(input logic [9:0] d);
        wvalid = 1'b1;
        wdata  = d;
        step();
        wvalid = 1'b0;
    endtask

    initial begin
        rst_n = 0; enable = 0; clk_div = 3; wdata = 0; wvalid = 0;
        flush = 0; underflow_clr = 0;
        m_cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Preloaded codes stepped out every 4 cycles, then underflow
        push_word(10'h000);
        push_word(10'h3FF);
        push_word(10'h155);
        clk_div = 3;
        enable  = 1'b1;
        repeat (3 + W + 20) step();
        enable = 1'b0;
        underflow_clr = 1'b1;
        step();

        // Overfill a depth-16 FIFO, then drain with ticks every cycle while writing
        wvalid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wdata = 10'($urandom);
            step();
        end
        clk_div = 0;
        enable  = 1'b1;
        repeat (3 + W + 6) begin
            wdata = 10'($urandom);
            step();
        end
        wvalid = 1'b0;
        repeat (20) step();

        // Flush, push and tick in one cycle, clear underflow afterwards
        underflow_clr = 1'b1;
        step();
        wvalid = 1'b1; wdata = 10'h2AA;
        step();
        flush = 1'b1; wdata = 10'h0F0;
        step();
        wvalid = 1'b0;
        underflow_clr = 1'b1;
        step();
        step();
        enable = 1'b0;
        step();

        // Drop enable mid-RUN with words queued, then replay the sequence
        for (int i = 0; i < 8; i++) push_word(10'($urandom));
        clk_div = 5;
        enable  = 1'b1;
        repeat (3 + W + 18) step();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        repeat (3 + W + 12) step();

        // Randomized traffic with occasional flush, clear, enable and rate changes
        for (int i = 0; i < 2500; i++) begin
            wvalid        = 1'($urandom);
            wdata         = 10'($urandom);
            flush         = ($urandom_range(0, 63) == 0);
            underflow_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0)  clk_div = PW'($urandom_range(0, 4));
            step();
        end
        wvalid = 1'b0;

        // Asynchronous reset in the middle of WARMUP
        enable = 1'b0;
        step();
        for (int i = 0; i < 3; i++) push_word(10'($urandom));
        enable = 1'b1;
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dac_sample_sequencer
`default_nettype wire

// File: doc/dac_sample_sequencer.md
# dac_sample_sequencer

Sample sequencer for the 10-bit segmented-capacitor DAC macro. Buffers 10-bit codes from a bus-side writer in a small FIFO and drives the macro's EN, RST and SELD[9:0] pins. Codes are released at a programmable sample rate, after a controlled reset and warm-up sequence. Sits between the register/bus wrapper and the analog macro; all outputs are registered and glitch-free.

## Interface
- FIFO_DEPTH, 16: sample FIFO depth; power of two, minimum 2.
- PRESC_W, 16: width of the sample-period divider.
- WARMUP_CYC, 32: clk cycles dac_en is held high before the first sample tick.
- clk  in  1  block clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  level; 1 runs the sequence, 0 returns to IDLE.
- clk_div  in  PRESC_W  sample period = clk_div+1 clk cycles.
- wdata  in  10  sample code.
- wvalid  in  1  write request.
- wready  out  1  FIFO not full; write accepted when wvalid&&wready.
- flush  in  1  single-cycle pulse; empties the FIFO.
- underflow_clr  in  1  pulse; clears the underflow flag.
- dac_en  out  1  to macro EN.
- dac_rst  out  1  to macro RST, active-high.
- dac_sel  out  10  to macro SELD9..SELD0.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.
- underflow  out  1  sticky; a tick found the FIFO empty.
- busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE: dac_en=0, dac_sel=0, dac_rst=0.
  - RESET: dac_rst=1 for exactly 2 cycles.
  - WARMUP: dac_en=1, counts WARMUP_CYC cycles.
  - RUN: dac_en=1.
- Transitions:
  - IDLE→RESET when enable=1.
  - RESET→WARMUP after 2 cycles.
  - WARMUP→RUN after WARMUP_CYC cycles.
  - Any state→IDLE on the cycle after enable=0. Leaving for IDLE zeroes dac_en and dac_sel and reloads all counters.
- In RUN, the prescaler counts 0..clk_div; a tick fires at terminal count.
  - On a tick with FIFO non-empty: pop the head and register it onto dac_sel.
  - On a tick with FIFO empty: hold dac_sel and set underflow.
- FIFO contents survive enable=0; only flush or reset clears them.
- flush has priority over a same-cycle push and a same-cycle pop.
  - The pushed word is dropped.
  - A same-cycle tick sees empty and sets underflow.
- Simultaneous push and pop: level unchanged. wready=!full, evaluated without the concurrent pop.
- Pointer arithmetic wraps modulo FIFO_DEPTH. The level counter is one bit wider so full and empty are distinct.
- underflow_clr and a same-cycle underflow event: the set wins.
- clk_div changes take effect at the next prescaler reload; the running count is not truncated.
- clk_div=0: a tick on every RUN cycle.

## Timing
- Reset values:
  - dac_en=0, dac_rst=0, dac_sel=0, underflow=0, busy=0.
  - fifo_level=0, wready=1; state IDLE.
- Sequence from enable rising in cycle 0:
  - RESET entered, with dac_rst=1, in cycles 1-2.
  - dac_en=1 from cycle 3.
  - RUN entered at cycle 3+WARMUP_CYC.
  - First tick clk_div cycles after RUN entry. dac_sel is visible the following cycle.
- Write latency: a word accepted in cycle n is poppable from cycle n+1; fifo_level updates at n+1.
- enable deasserted in cycle n: dac_en=0, dac_sel=0, busy=0 at n+1.
- rst_n assert mid-operation: all outputs reach their reset values immediately (asynchronous). FIFO is emptied.

## Structure
- Shared package dac_seq_pkg holds:
  - State enum: IDLE, RESET, WARMUP, RUN.
  - DAC_BITS=10.
  - RESET_CYC=2.
- Sub-module dac_seq_fifo: synchronous FIFO with push/pop/flush, level, full/empty.
- The top level holds the FSM, prescaler and output registers.

## Test plan
- Reset then enable, WARMUP_CYC=32: dac_rst high in cycles 1-2, dac_en from cycle 3, no dac_sel change before cycle 35+clk_div.
- Preload 0x000, 0x3FF, 0x155 with clk_div=3, then enable: dac_sel steps through the three codes exactly 4 cycles apart. Fourth tick sets underflow; dac_sel holds 0x155.
- Write 17 words into a depth-16 FIFO: wready low after 16, 17th dropped, fifo_level=16. A pop plus push at full keeps level 16.
- flush, push and tick in the same cycle: fifo_level=0, pushed word lost, underflow=1. underflow_clr the next cycle clears it.
- Drop enable mid-RUN with 5 words queued: dac_en=0, dac_sel=0 next cycle, fifo_level stays 5. Re-enable replays the full RESET/WARMUP sequence.
- Assert rst_n low mid-WARMUP: outputs clear asynchronously, fifo_level=0, state IDLE after release.
